tx_gearbox: RTL and testbench

64b66b transmit synchronous gearbox with a 32-bit interface. It is the TX-side counterpart of the RX gearbox in the PCS. Each cycle it accepts one 32-bit half of a 66-bit block: the lower half together with its 2-bit header, then the upper half. It emits a continuous 32-bit serial-ordered word stream to the transceiver. A free-running 0-32 sequence counter stalls the upstream encoder/scrambler for one cycle in every 33 to absorb the 2-bit header overhead.

---
 rtl/tx_gearbox.sv | 106 ++++++++++
 tb/tb_tx_gearbox.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tx_gearbox.sv
// -----------------------------------------------------------------------------
// tx_gearbox
//
// 64b66b transmit synchronous gearbox, 32-bit interface.
//
// Each cycle the upstream encoder/scrambler supplies one half of a 66-bit block:
// the lower half plus its 2-bit sync header on even sequence values, then the
// upper half on odd values. The gearbox repacks the 66-bit blocks into a
// continuous 32-bit word stream in which bit 0 is transmitted first. A free-running
// 0..32 sequence counter drops o_ready for one cycle in 33. That cycle drains the
// 32 bits of header overhead accumulated over the previous 16 blocks.
//
// Ports:
//   i_clk         clock
//   i_reset       synchronous, active-high reset
//   i_data        block half: bits 31:0 on even seq, bits 63:32 on odd seq
//   i_header      sync header, sampled only on even seq
//   o_ready       upstream must present a word this cycle (low only at seq 32)
//   o_data        gearbox output word, bit 0 first on the line
//   o_data_valid  o_data carries block-derived data
//   o_seq         current sequence counter value
// -----------------------------------------------------------------------------
module tx_gearbox #(
    parameter bit REGISTER_OUTPUT = 1'b1,
    localparam int DATA_WIDTH = 32,
    localparam int HEADER_WIDTH = 2,
    localparam int SEQUENCE_WIDTH = 6
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [DATA_WIDTH-1:0]     i_data,
    input  logic [HEADER_WIDTH-1:0]   i_header,
    output logic                      o_ready,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic                      o_data_valid,
    output logic [SEQUENCE_WIDTH-1:0] o_seq
);

    localparam logic [SEQUENCE_WIDTH-1:0] SEQ_LAST = SEQUENCE_WIDTH'(32);
    localparam int COMB_WIDTH = 2 * DATA_WIDTH;

    logic [SEQUENCE_WIDTH-1:0] seq_q, seq_d;
    logic [DATA_WIDTH-1:0]     store_q, store_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      valid_q, valid_d;

    logic                      last;
    logic [SEQUENCE_WIDTH-1:0] fill;
    logic [COMB_WIDTH-1:0]     append;
    logic [COMB_WIDTH-1:0]     combined;

    always_comb begin
        last = (seq_q == SEQ_LAST);
        // The fill level is a pure function of the sequence value. It starts at
        // 0 and gains 2 header bits per block (every even/odd pair). That gives
        // s + s[0], which reaches 32 at seq 31 and stays 32 at seq 32.
        fill = seq_q + {{(SEQUENCE_WIDTH-1){1'b0}}, seq_q[0]};

        append = '0;
        if (!last && !i_reset) begin
            if (!seq_q[0]) begin
                append = {{(COMB_WIDTH-DATA_WIDTH-HEADER_WIDTH){1'b0}}, i_data, i_header};
            end else begin
                append = {{DATA_WIDTH{1'b0}}, i_data};
            end
        end

        // Store bits above the fill level are always zero, so OR-ing is enough.
        // The even-seq maximum is fill 30 + 34 bits = 64, so nothing is lost.
        // At seq 32 nothing is appended, which drains the full store and leaves
        // the upper half, and therefore the next store, at zero.
        combined = {{DATA_WIDTH{1'b0}}, store_q} | (append << fill);

        data_d  = combined[DATA_WIDTH-1:0];
        store_d = combined[COMB_WIDTH-1:DATA_WIDTH];
        seq_d   = last ? '0 : seq_q + SEQUENCE_WIDTH'(1);
        valid_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            seq_q   <= '0;
            store_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            store_q <= store_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    generate
        if (REGISTER_OUTPUT) begin : g_reg_out
            assign o_data = data_q;
        end else begin : g_comb_out
            assign o_data = i_reset ? '0 : data_d;
        end
    endgenerate

    assign o_data_valid = valid_q;
    assign o_ready      = !last;
    assign o_seq        = seq_q;

endmodule

// File: tb/tb_tx_gearbox.sv
// -----------------------------------------------------------------------------
// tb_tx_gearbox
//
// Directed bench for tx_gearbox (registered-output configuration).
// A table of hand-computed vectors covers the first words after reset. A
// bit-serial reference model then handles the longer runs: zero fill, an
// incrementing pattern with don't-care inputs at seq 32, a mid-block reset,
// and a long random run.
// -----------------------------------------------------------------------------
module tb_tx_gearbox;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_data;
    logic [1:0]  i_header;
    logic        o_ready;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic [5:0]  o_seq;

    tx_gearbox #(.REGISTER_OUTPUT(1'b1)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_data       (i_data),
        .i_header     (i_header),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_seq        (o_seq)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ready_cnt = 0;
    int mseq = 0;
    bit exp_q[$];

    typedef struct {
        logic [31:0] data;
        logic [1:0]  header;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (model seq %0d)", name, act, exp, mseq);
        end
    endtask

    task automatic do_reset();
        i_reset  = 1'b1;
        i_data   = $urandom;
        i_header = 2'($urandom);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        mseq = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_state();
        check("reset o_seq", 32'(o_seq), 32'd0);
        check("reset o_data", o_data, 32'd0);
        check("reset o_data_valid", 32'(o_data_valid), 32'd0);
        check("reset o_ready", 32'(o_ready), 32'd1);
    endtask

    // mode 0: all zeros; mode 1: incrementing pattern; mode 2: random
    task automatic run(input int n, input int mode);
        logic [31:0] d;
        logic [1:0]  h;
        logic [31:0] e;
        int s;
        for (int c = 0; c < n; c++) begin
            s = mseq;
            check("o_seq", 32'(o_seq), 32'(s));
            check("o_ready", 32'(o_ready), (s != 32) ? 32'd1 : 32'd0);
            if (o_ready) ready_cnt++;
            case (mode)
                0: begin d = '0; h = '0; end
                1: begin
                    d = 32'h1000_0000 + 32'(s);
                    h = s[0] ? 2'b01 : 2'b10;
                    if (s == 32) begin d = 32'hFFFF_FFFF; h = 2'b11; end
                end
                default: begin d = $urandom; h = 2'($urandom); end
            endcase
            if (s != 32) begin
                if (s[0] == 1'b0) begin
                    exp_q.push_back(h[0]);
                    exp_q.push_back(h[1]);
                end
                for (int b = 0; b < 32; b++) exp_q.push_back(d[b]);
            end
            i_data   = d;
            i_header = h;
            @(posedge i_clk);
            #1;
            e = '0;
            for (int b = 0; b < 32; b++) begin
                if (exp_q.size() > 0) e[b] = exp_q.pop_front();
            end
            check("o_data", o_data, e);
            check("o_data_valid", 32'(o_data_valid), 32'd1);
            if (mode == 1 && s == 32) check("seq32 verbatim word 31", o_data, 32'h1000_001F);
            mseq = (s == 32) ? 0 : s + 1;
        end
    endtask

    initial begin
        vecs[0] = '{32'hC000_0001, 2'b01, 32'h0000_0005};
        vecs[1] = '{32'h0000_0003, 2'b10, 32'h0000_000F};
        vecs[2] = '{32'h8000_0000, 2'b10, 32'h0000_0008};
        vecs[3] = '{32'h1234_5678, 2'b11, 32'h2345_6788};
        vecs[4] = '{32'h0000_0000, 2'b00, 32'h0000_0001};

        i_reset  = 1'b1;
        i_data   = '0;
        i_header = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        mseq = 0;
        check_reset_state();

        // Hand-computed vectors straight after reset
        for (int i = 0; i < 5; i++) begin
            i_data   = vecs[i].data;
            i_header = vecs[i].header;
            @(posedge i_clk);
            #1;
            check($sformatf("vec%0d o_data", i), o_data, vecs[i].exp_data);
            check($sformatf("vec%0d o_seq", i), 32'(o_seq), 32'(i + 1));
            check($sformatf("vec%0d o_data_valid", i), 32'(o_data_valid), 32'd1);
        end

        // Zero inputs: full counter period plus wrap
        do_reset();
        check_reset_state();
        run(34, 0);

        // Incrementing pattern, don't-care inputs at seq 32
        do_reset();
        run(33, 1);
        run(33, 1);

        // Reset mid-block at seq 17
        do_reset();
        run(17, 2);
        check("pre-reset seq", 32'(o_seq), 32'd17);
        do_reset();
        check_reset_state();
        run(66, 2);

        // Long random run with o_ready duty measurement
        do_reset();
        ready_cnt = 0;
        run(63 * 33, 2);
        check("o_ready duty", 32'(ready_cnt), 32'(63 * 32));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
